uart_receiver: RTL and testbench

//  Serial-to-parallel UART receive stage, the line-side counterpart of the team's UART transmitter.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_receiver.sv | 138 +++++++++++++
 tb/tb_uart_receiver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud codes, bit-period table and receiver states.
// Used by both the transmitter and the receiver so one baud_set value drives both.
package uart_pkg;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    localparam int CNT_W = 13;

    localparam logic [CNT_W-1:0] BIT_MAX_9600   = 13'd5207;
    localparam logic [CNT_W-1:0] BIT_MAX_19200  = 13'd2603;
    localparam logic [CNT_W-1:0] BIT_MAX_38400  = 13'd1301;
    localparam logic [CNT_W-1:0] BIT_MAX_57600  = 13'd867;
    localparam logic [CNT_W-1:0] BIT_MAX_115200 = 13'd433;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_e;

    // Unlisted codes fall back to the slowest rate.
    function automatic logic [CNT_W-1:0] bit_max(input logic [2:0] baud_set);
        logic [CNT_W-1:0] v;
        case (baud_set)
            BAUD_19200:  v = BIT_MAX_19200;
            BAUD_38400:  v = BIT_MAX_38400;
            BAUD_57600:  v = BIT_MAX_57600;
            BAUD_115200: v = BIT_MAX_115200;
            default:     v = BIT_MAX_9600;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line, plus falling-edge detect.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_d;

    // Reset to idle-high so releasing reset never looks like a start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '1;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_rx_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rx_s = r_sync[SYNC_STAGES-1];
    assign o_fall = r_rx_d & ~o_rx_s;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: mid-bit sampling, per-frame baud latch, framing-error detect.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_baud_set,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_rx_done,
    output logic       o_frame_err,
    output logic       o_rx_busy
);

    logic             w_rx_s;
    logic             w_fall;
    rx_state_e        r_state;
    rx_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_bit_max;
    logic [CNT_W-1:0] w_bit_max_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [7:0]       r_data;
    logic [7:0]       w_data_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_ferr;
    logic             w_ferr_nxt;
    logic             r_busy;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_rx   (i_rx),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_max <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_max <= w_bit_max_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_done    <= w_done_nxt;
            r_ferr    <= w_ferr_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 13'd1;
        w_bit_max_nxt = r_bit_max;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_done_nxt    = 1'b0;
        w_ferr_nxt    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall) begin
                    w_state_nxt   = S_START;
                    w_bit_max_nxt = bit_max(i_baud_set);
                end
            end
            S_START: begin
                // A start bit that is gone by mid-bit was a glitch.
                if (r_cnt == (r_bit_max >> 1)) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == r_bit_max) begin
                    w_cnt_nxt              = '0;
                    w_shift_nxt[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == r_bit_max) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_rx_done   = r_done;
    assign o_frame_err = r_ferr;
    assign o_rx_busy   = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level model with event queue and timing windows.
module tb_uart_receiver;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] baud_set = 3'd4;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    uart_receiver #(
        .SYNC_STAGES(S)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_baud_set  (baud_set),
        .i_rx        (rx),
        .o_data      (data),
        .o_rx_done   (rx_done),
        .o_frame_err (frame_err),
        .o_rx_busy   (rx_busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         err;
        logic [7:0] d;
        int         t;
    } ev_t;

    ev_t        q[$];
    ev_t        cur;
    logic [7:0] m_data = 8'h00;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_done = 0;
    int         n_ferr = 0;
    int         last_t = 0;
    bit         prev_strobe = 1'b0;

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Clocks per bit from the nominal line rate at 50 MHz.
    function automatic int period(input logic [2:0] b);
        int rate;
        case (b)
            3'd1:    rate = 19200;
            3'd2:    rate = 38400;
            3'd3:    rate = 57600;
            3'd4:    rate = 115200;
            default: rate = 9600;
        endcase
        return 50_000_000 / rate;
    endfunction

    // Compare process: every strobe must match the head of the expected-event queue.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            chk({data, rx_done, frame_err, rx_busy} == '0, "reset_outputs",
                int'({data, rx_done, frame_err, rx_busy}), 0);
            prev_strobe = 1'b0;
        end else begin
            if (rx_done || frame_err) begin
                chk(!(rx_done && frame_err), "strobe_exclusive", 1, 0);
                chk(!prev_strobe, "strobe_consecutive", 1, 0);
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_strobe", rx_done ? 1 : 2, 0);
                end else begin
                    cur = q.pop_front();
                    chk(frame_err == cur.err, "strobe_kind", int'(frame_err), int'(cur.err));
                    chk(cyc >= cur.t - 3 && cyc <= cur.t + 3, "strobe_time", cyc, cur.t);
                    if (!cur.err) m_data = cur.d;
                end
                if (rx_done) begin
                    n_done++;
                    last_t = cyc;
                end else begin
                    n_ferr++;
                end
            end else if (q.size() > 0 && cyc > q[0].t + 3) begin
                chk(1'b0, "missed_strobe", cyc, q[0].t);
                void'(q.pop_front());
            end
            chk(data == m_data, "data_hold", int'(data), int'(m_data));
            prev_strobe = rx_done || frame_err;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] b, input int p, input bit stop);
        ev_t e;
        e.err = !stop;
        e.d   = b;
        e.t   = cyc + (19 * p) / 2 + S + 1;
        q.push_back(e);
        rx = 1'b0;
        idle(p);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(p);
        end
        rx = stop;
        idle(p);
    endtask

    task automatic glitch(input int p, input string nm);
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(p / 2 - 108);
        chk(rx_busy == 1'b1, {nm, "_busy_mid"}, int'(rx_busy), 1);
        idle(18);
        chk(rx_busy == 1'b0, {nm, "_busy_drop"}, int'(rx_busy), 0);
    endtask

    int         f;
    int         n0;
    logic [7:0] ab;

    initial begin
        @(negedge clk);
        idle(5);
        rst = 1'b0;
        idle(10);

        baud_set = 3'd4;
        n0 = n_done;
        f  = cyc;
        drive_frame(8'hA5, period(3'd4), 1'b1);
        idle(20);
        chk(n_done == n0 + 1, "t1_count", n_done - n0, 1);
        chk(data == 8'hA5, "t1_data", int'(data), 8'hA5);
        chk(last_t - f >= 4123 + S - 2 && last_t - f <= 4123 + S + 3,
            "t1_latency", last_t - f, 4123 + S + 1);

        baud_set = 3'd0;
        glitch(period(3'd0), "t2_b0");
        idle(20);
        baud_set = 3'd1;
        glitch(period(3'd1), "t2_b1");
        idle(20);
        baud_set = 3'd7;
        glitch(period(3'd7), "t2_b7");
        idle(20);

        baud_set = 3'd4;
        drive_frame(8'h3C, period(3'd4), 1'b0);
        idle(3 * period(3'd4));
        chk(rx_busy == 1'b1, "t3_break_busy", int'(rx_busy), 1);
        chk(n_ferr == 1, "t3_ferr_count", n_ferr, 1);
        chk(data == 8'hA5, "t3_data_kept", int'(data), 8'hA5);
        rx = 1'b1;
        idle(20);
        chk(rx_busy == 1'b0, "t3_break_exit", int'(rx_busy), 0);
        drive_frame(8'h5A, period(3'd4), 1'b1);
        idle(20);

        baud_set = 3'd2;
        n0 = n_done;
        drive_frame(8'h00, period(3'd2), 1'b1);
        drive_frame(8'hFF, period(3'd2), 1'b1);
        drive_frame(8'h55, period(3'd2), 1'b1);
        idle(20);
        chk(n_done == n0 + 3, "t4_count", n_done - n0, 3);
        chk(data == 8'h55, "t4_last", int'(data), 8'h55);

        baud_set = 3'd4;
        ab = 8'hE7;
        rx = 1'b0;
        idle(period(3'd4));
        for (int i = 0; i < 4; i++) begin
            rx = ab[i];
            idle(period(3'd4));
        end
        rx = ab[4];
        idle(200);
        chk(rx_busy == 1'b1, "t5_busy_pre", int'(rx_busy), 1);
        rst = 1'b1;
        rx  = 1'b1;
        q.delete();
        m_data = 8'h00;
        idle(6);
        rst = 1'b0;
        idle(20);
        drive_frame(8'h81, period(3'd4), 1'b1);
        idle(20);
        chk(data == 8'h81, "t5_data", int'(data), 8'h81);

        baud_set = 3'd4;
        fork
            drive_frame(8'hC3, period(3'd4), 1'b1);
            begin
                idle(1500);
                baud_set = 3'd0;
            end
        join
        idle(20);
        chk(data == 8'hC3, "t6_data", int'(data), 8'hC3);
        glitch(period(3'd0), "t6_next");
        idle(20);

        baud_set = 3'd3;
        drive_frame(8'($urandom_range(0, 255)), period(3'd3), 1'b1);
        baud_set = 3'd4;
        for (int i = 0; i < 4; i++) begin
            idle($urandom_range(0, 15));
            drive_frame(8'($urandom_range(0, 255)), period(3'd4), 1'b1);
        end

        idle(50);
        chk(q.size() == 0, "pending_events", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
